rtc_banco_registros_burst: RTL and testbench

//  Parametrised RTC data distributor and holding register bank. It captures bytes read from the RTC into NUM_REGS

---
 rtl/rtc_banco_registros_burst.sv | 189 ++++++++++++++++++
 tb/tb_rtc_banco_registros_burst.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_banco_registros_burst.sv
// rtc_banco_registros_burst
// RTC data distributor and holding register bank. Bytes arriving from the RTC bus
// controller are captured in one of two ways:
//   - an addressed single write, which updates the visible bank directly;
//   - an auto-incrementing burst, which fills a shadow bank and is then committed
//     to the outputs in a single step, so consumers never see a torn time value.
// Optional build macro: RTC_BCD_CHECK_EN
//   When defined, every accepted byte is checked nibble by nibble and any nibble
//   above 9 rejects it. A rejected single write is dropped. A rejected burst byte
//   aborts the burst. When undefined, every byte is accepted and out_bcd_err stays 0.

module rtc_banco_registros_burst #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned NUM_REGS    = 10,
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_wr_en,
    input  logic [ADDR_W-1:0]            in_addr_mem_local,
    input  logic [DATA_W-1:0]            in_dato_rtc,
    input  logic                         in_burst_start,
    output logic [NUM_REGS*DATA_W-1:0]   out_regs,
    output logic [NUM_REGS-1:0]          out_reg_valid,
    output logic                         out_busy,
    output logic                         out_commit,
    output logic                         out_addr_err,
    output logic                         out_timeout,
    output logic                         out_bcd_err
);

    localparam int unsigned PTR_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_REGS - 1);
    // Value of the idle counter on the last idle cycle that is still tolerated
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BURST  = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] bank   [NUM_REGS];
    logic [DATA_W-1:0] shadow [NUM_REGS];
    logic [PTR_W-1:0]  ptr;
    logic [CNT_W-1:0]  idle_cnt;

    logic              byte_ok_c;
    logic              addr_ok_c;
    logic              burst_active_c;
    logic              timeout_hit_c;
    logic [PTR_W-1:0]  eff_ptr_c;
    logic [PTR_W-1:0]  wr_idx_c;

`ifdef RTC_BCD_CHECK_EN
    localparam int unsigned NIBBLES = DATA_W / 4;

    // A byte is acceptable only if every nibble is a decimal digit
    always_comb begin
        byte_ok_c = 1'b1;
        for (int unsigned n = 0; n < NIBBLES; n++) begin
            if (in_dato_rtc[n*4 +: 4] > 4'd9) begin
                byte_ok_c = 1'b0;
            end
        end
    end
`else
    assign byte_ok_c = 1'b1;
`endif

    // Decode of the current request: address range, burst slot and timeout
    always_comb begin
        addr_ok_c      = (32'(in_addr_mem_local) < NUM_REGS);
        wr_idx_c       = PTR_W'(in_addr_mem_local);
        burst_active_c = (state == S_BURST) || ((state == S_IDLE) && in_burst_start);
        // A (re)start always begins at register 0, even with a byte in the same cycle
        eff_ptr_c      = in_burst_start ? '0 : ptr;
        timeout_hit_c  = (TIMEOUT_CYC != 0) && (idle_cnt == TO_LAST);
    end

    // Committed bank is exposed as one flat vector, register i at [i*DATA_W +: DATA_W]
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign out_regs[g*DATA_W +: DATA_W] = bank[g];
    end

    // Control FSM, shadow/committed banks and registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            ptr           <= '0;
            idle_cnt      <= '0;
            out_reg_valid <= '0;
            out_busy      <= 1'b0;
            out_commit    <= 1'b0;
            out_addr_err  <= 1'b0;
            out_timeout   <= 1'b0;
            out_bcd_err   <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                bank[i]   <= '0;
                shadow[i] <= '0;
            end
        end else begin
            out_commit   <= 1'b0;
            out_addr_err <= 1'b0;
            out_timeout  <= 1'b0;
            out_bcd_err  <= 1'b0;

            case (state)
                S_IDLE, S_BURST: begin
                    if (burst_active_c) begin
                        if (in_wr_en && !byte_ok_c) begin
                            // Bad byte: drop the partial burst and resync shadow to the visible bank
                            state       <= S_IDLE;
                            ptr         <= '0;
                            idle_cnt    <= '0;
                            out_busy    <= 1'b0;
                            out_bcd_err <= 1'b1;
                            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                                shadow[i] <= bank[i];
                            end
                        end else if (in_wr_en) begin
                            shadow[eff_ptr_c] <= in_dato_rtc;
                            idle_cnt          <= '0;
                            out_busy          <= 1'b1;
                            if (eff_ptr_c == LAST_PTR) begin
                                state <= S_COMMIT;
                                ptr   <= '0;
                            end else begin
                                state <= S_BURST;
                                ptr   <= eff_ptr_c + PTR_W'(1);
                            end
                        end else if (in_burst_start) begin
                            state    <= S_BURST;
                            ptr      <= '0;
                            idle_cnt <= '0;
                            out_busy <= 1'b1;
                        end else if (timeout_hit_c) begin
                            // Source went quiet: abandon the burst without touching the outputs
                            state       <= S_IDLE;
                            ptr         <= '0;
                            idle_cnt    <= '0;
                            out_busy    <= 1'b0;
                            out_timeout <= 1'b1;
                            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                                shadow[i] <= bank[i];
                            end
                        end else if (TIMEOUT_CYC != 0) begin
                            idle_cnt <= idle_cnt + CNT_W'(1);
                        end
                    end else if (in_wr_en) begin
                        if (!addr_ok_c) begin
                            out_addr_err <= 1'b1;
                        end else if (!byte_ok_c) begin
                            out_bcd_err <= 1'b1;
                        end else begin
                            // Single write lands in both banks so shadow always mirrors the outputs in IDLE
                            bank[wr_idx_c]          <= in_dato_rtc;
                            shadow[wr_idx_c]        <= in_dato_rtc;
                            out_reg_valid[wr_idx_c] <= 1'b1;
                            out_commit              <= 1'b1;
                        end
                    end
                end

                S_COMMIT: begin
                    // Whole burst becomes visible at once; inputs this cycle are ignored
                    for (int unsigned i = 0; i < NUM_REGS; i++) begin
                        bank[i] <= shadow[i];
                    end
                    out_reg_valid <= '1;
                    out_commit    <= 1'b1;
                    out_busy      <= 1'b0;
                    state         <= S_IDLE;
                end

                default: begin
                    state    <= S_IDLE;
                    ptr      <= '0;
                    idle_cnt <= '0;
                    out_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_banco_registros_burst.sv
// Self-checking bench for rtc_banco_registros_burst: a directed table, hand-written
// multi-cycle sequences and a randomized run, all checked against a queue-based
// reference model of the bank.

module tb_rtc_banco_registros_burst;

    localparam int unsigned NR = 10;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 4;
    localparam int unsigned TO = 16;

    logic              clk;
    logic              reset;
    logic              in_wr_en;
    logic [AW-1:0]     in_addr_mem_local;
    logic [DW-1:0]     in_dato_rtc;
    logic              in_burst_start;
    logic [NR*DW-1:0]  out_regs;
    logic [NR-1:0]     out_reg_valid;
    logic              out_busy;
    logic              out_commit;
    logic              out_addr_err;
    logic              out_timeout;
    logic              out_bcd_err;

    rtc_banco_registros_burst #(
        .DATA_W      (DW),
        .NUM_REGS    (NR),
        .ADDR_W      (AW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .in_wr_en          (in_wr_en),
        .in_addr_mem_local (in_addr_mem_local),
        .in_dato_rtc       (in_dato_rtc),
        .in_burst_start    (in_burst_start),
        .out_regs          (out_regs),
        .out_reg_valid     (out_reg_valid),
        .out_busy          (out_busy),
        .out_commit        (out_commit),
        .out_addr_err      (out_addr_err),
        .out_timeout       (out_timeout),
        .out_bcd_err       (out_bcd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    // Visible bank, valid flags, and the bytes collected so far in an open burst.
    logic [7:0]    m_bank [NR];
    logic [NR-1:0] m_valid;
    logic [7:0]    m_q [$];
    bit            m_in_burst;
    bit            m_commit_pend;
    int            m_idle;
    bit            e_commit, e_aerr, e_to, e_bcd;

    function automatic bit bcd_ok(input logic [7:0] d);
`ifdef RTC_BCD_CHECK_EN
        return ((int'(d) % 16) <= 9) && ((int'(d) / 16) <= 9);
`else
        return 1'b1;
`endif
    endfunction

    function automatic void model_step(input logic r, input logic wr, input logic st,
                                       input logic [3:0] a, input logic [7:0] d);
        e_commit = 1'b0; e_aerr = 1'b0; e_to = 1'b0; e_bcd = 1'b0;
        if (r) begin
            for (int i = 0; i < NR; i++) m_bank[i] = 8'h00;
            m_valid = '0;
            m_q.delete();
            m_in_burst = 1'b0;
            m_commit_pend = 1'b0;
            m_idle = 0;
        end else if (m_commit_pend) begin
            for (int i = 0; i < NR; i++) m_bank[i] = m_q[i];
            m_valid = '1;
            e_commit = 1'b1;
            m_commit_pend = 1'b0;
            m_q.delete();
        end else if (m_in_burst || st) begin
            if (st) begin
                m_q.delete();
                m_in_burst = 1'b1;
                m_idle = 0;
            end
            if (wr) begin
                if (!bcd_ok(d)) begin
                    m_in_burst = 1'b0;
                    m_q.delete();
                    e_bcd = 1'b1;
                end else begin
                    m_q.push_back(d);
                    m_idle = 0;
                    if (m_q.size() == NR) begin
                        m_in_burst = 1'b0;
                        m_commit_pend = 1'b1;
                    end
                end
            end else if (!st) begin
                m_idle++;
                if (TO != 0 && m_idle == TO) begin
                    m_in_burst = 1'b0;
                    m_q.delete();
                    e_to = 1'b1;
                end
            end
        end else if (wr) begin
            if (int'(a) >= NR) e_aerr = 1'b1;
            else if (!bcd_ok(d)) e_bcd = 1'b1;
            else begin
                m_bank[a] = d;
                m_valid[a] = 1'b1;
                e_commit = 1'b1;
            end
        end
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] slice(input int i);
        return out_regs[i*DW +: DW];
    endfunction

    task automatic compare_model();
        logic [NR*DW-1:0] er;
        for (int i = 0; i < NR; i++) er[i*DW +: DW] = m_bank[i];
        check("regs",     out_regs,      er);
        check("valid",    out_reg_valid, m_valid);
        check("busy",     out_busy,      m_in_burst || m_commit_pend);
        check("commit",   out_commit,    e_commit);
        check("addr_err", out_addr_err,  e_aerr);
        check("timeout",  out_timeout,   e_to);
        check("bcd_err",  out_bcd_err,   e_bcd);
    endtask

    // Drive one cycle of inputs, advance the model over the same edge, then compare
    task automatic run_cycle(input logic r, input logic wr, input logic st,
                             input logic [3:0] a, input logic [7:0] d);
        reset = r; in_wr_en = wr; in_burst_start = st;
        in_addr_mem_local = a; in_dato_rtc = d;
        @(posedge clk);
        model_step(r, wr, st, a, d);
        #1;
        compare_model();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic       r;
        logic       wr;
        logic       st;
        logic [3:0] addr;
        logic [7:0] data;
        logic       e_busy;
        logic       e_commit;
        logic       e_aerr;
        logic [9:0] e_valid;
        int         sl;
        logic [7:0] e_sl;
    } vec_t;

    localparam int NT = 10;
    vec_t tbl [NT];

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int commits, c_at, to_cnt, to_at, bcds, mode;
        logic r, wr, st;
        logic [3:0] a;
        logic [7:0] d;
        logic [7:0] b5 [10];

        //          r     wr    st    addr   data   busy  commit aerr  valid    slice  value
        tbl[0] = '{1'b1, 1'b0, 1'b0, 4'd0,  8'h00, 1'b0, 1'b0, 1'b0, 10'h000, 2, 8'h00};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 4'd2,  8'h15, 1'b0, 1'b1, 1'b0, 10'h004, 2, 8'h15};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 4'd0,  8'h00, 1'b0, 1'b0, 1'b0, 10'h004, 2, 8'h15};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 4'd12, 8'hAA, 1'b0, 1'b0, 1'b1, 10'h004, 2, 8'h15};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 4'd0,  8'h00, 1'b0, 1'b0, 1'b0, 10'h004, 9, 8'h00};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 4'd9,  8'h42, 1'b0, 1'b1, 1'b0, 10'h204, 9, 8'h42};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 4'd0,  8'h00, 1'b1, 1'b0, 1'b0, 10'h204, 0, 8'h00};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 4'd3,  8'h77, 1'b1, 1'b0, 1'b0, 10'h204, 3, 8'h00};
        tbl[8] = '{1'b0, 1'b1, 1'b1, 4'd5,  8'h11, 1'b1, 1'b0, 1'b0, 10'h204, 0, 8'h00};
        tbl[9] = '{1'b0, 1'b1, 1'b0, 4'd12, 8'h99, 1'b1, 1'b0, 1'b0, 10'h204, 9, 8'h42};

        for (int k = 0; k < NT; k++) begin
            run_cycle(tbl[k].r, tbl[k].wr, tbl[k].st, tbl[k].addr, tbl[k].data);
            check($sformatf("tbl%0d.busy", k),     out_busy,          tbl[k].e_busy);
            check($sformatf("tbl%0d.commit", k),   out_commit,        tbl[k].e_commit);
            check($sformatf("tbl%0d.addr_err", k), out_addr_err,      tbl[k].e_aerr);
            check($sformatf("tbl%0d.valid", k),    out_reg_valid,     tbl[k].e_valid);
            check($sformatf("tbl%0d.slice", k),    slice(tbl[k].sl),  tbl[k].e_sl);
        end

        // Full back-to-back burst; start+write during COMMIT must be dropped
        run_cycle(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
        run_cycle(1'b0, 1'b0, 1'b1, 4'd0, 8'h00);
        commits = 0; c_at = -1;
        for (int i = 0; i < 10; i++) begin
            run_cycle(1'b0, 1'b1, 1'b0, 4'd7, 8'(i));
            if (out_commit) commits++;
        end
        for (int i = 1; i < 5; i++) begin
            if (i == 1) run_cycle(1'b0, 1'b1, 1'b1, 4'd2, 8'h99);
            else        run_cycle(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
            if (out_commit) begin
                commits++;
                if (c_at < 0) c_at = i;
            end
        end
        check("burst.commit_count", commits, 1);
        check("burst.commit_latency", c_at, 1);
        check("burst.slice2", slice(2), 8'h02);
        check("burst.slice9", slice(9), 8'h09);
        check("burst.busy_after", out_busy, 1'b0);

        // Partial burst left idle until it times out, then a normal single write
        run_cycle(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
        run_cycle(1'b0, 1'b0, 1'b1, 4'd0, 8'h00);
        for (int i = 0; i < 4; i++) run_cycle(1'b0, 1'b1, 1'b0, 4'd0, 8'(8'h21 + i));
        to_cnt = 0; to_at = -1;
        for (int k = 1; k <= 40; k++) begin
            run_cycle(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
            if (out_timeout) begin
                to_cnt++;
                if (to_at < 0) to_at = k;
            end
        end
        check("timeout.count", to_cnt, 1);
        check("timeout.at_cycle", to_at, TO);
        check("timeout.regs_unchanged", out_regs, '0);
        run_cycle(1'b0, 1'b1, 1'b0, 4'd5, 8'h37);
        check("timeout.after_write", slice(5), 8'h37);
        check("timeout.after_valid", out_reg_valid, 10'h020);

        // Burst with a non-decimal byte in slot 3
        b5 = '{8'h10, 8'h11, 8'h12, 8'h1A, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19};
        run_cycle(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
        run_cycle(1'b0, 1'b0, 1'b1, 4'd0, 8'h00);
        commits = 0; bcds = 0;
        for (int i = 0; i < 13; i++) begin
            if (i < 10) run_cycle(1'b0, 1'b1, 1'b0, 4'd15, b5[i]);
            else        run_cycle(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
            if (out_commit) commits++;
            if (out_bcd_err) bcds++;
        end
`ifdef RTC_BCD_CHECK_EN
        check("bcd.err_count", bcds, 1);
        check("bcd.commit_count", commits, 0);
        check("bcd.slice3", slice(3), 8'h00);
`else
        check("bcd.err_count", bcds, 0);
        check("bcd.commit_count", commits, 1);
        check("bcd.slice3", slice(3), 8'h1A);
`endif

        // Reset in the middle of a burst, then a clean burst
        run_cycle(1'b0, 1'b1, 1'b0, 4'd1, 8'h55);
        run_cycle(1'b0, 1'b0, 1'b1, 4'd0, 8'h00);
        for (int i = 0; i < 6; i++) run_cycle(1'b0, 1'b1, 1'b0, 4'd0, 8'(8'h31 + i));
        run_cycle(1'b1, 1'b1, 1'b0, 4'd0, 8'h37);
        check("rstmid.regs", out_regs, '0);
        check("rstmid.valid", out_reg_valid, 10'h000);
        check("rstmid.busy", out_busy, 1'b0);
        run_cycle(1'b0, 1'b0, 1'b1, 4'd0, 8'h00);
        for (int i = 0; i < 10; i++) run_cycle(1'b0, 1'b1, 1'b0, 4'd3, 8'(8'h50 + i));
        run_cycle(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        run_cycle(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        check("rstmid.slice0", slice(0), 8'h50);
        check("rstmid.slice9", slice(9), 8'h59);
        check("rstmid.valid_all", out_reg_valid, 10'h3FF);

        // Randomized traffic: dense phases exercise bursts, sparse phases hit timeouts
        mode = 0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 64 == 0) mode = int'($urandom_range(0, 1));
            r = ($urandom_range(0, 499) == 0);
            if (mode == 0) begin
                wr = ($urandom_range(0, 99) < 70);
                st = ($urandom_range(0, 99) < 5);
            end else begin
                wr = ($urandom_range(0, 99) < 5);
                st = ($urandom_range(0, 99) < 2);
            end
            a = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) d = 8'($urandom);
            else d = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            run_cycle(r, wr, st, a, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
